// File: rtl/pll_power_sequencer.sv
// PLL power/gate sequencer: power-up, lock qualification, clock ungating,
// relock on lock loss, and an orderly gate-then-power-down.
//
//  state | meaning
//  OFF   | PLL unpowered, clock gated, waiting for en
//  PWRUP | power applied, settling for PWR_CYCLES
//  LOCK  | waiting for LOCK_STABLE consecutive lock_s cycles, bounded by LOCK_TIMEOUT
//  RUN   | clock ungated, clk_ready asserted
//  GATE  | clock gated again, power held for GATE_CYCLES
//  PWRDN | power removed, settling for PWR_CYCLES before OFF
//  FAULT | lock timeout; unpowered until en drops
module pll_power_sequencer #(
    parameter int CNT_W        = 16,
    parameter int PWR_CYCLES   = 16,
    parameter int LOCK_STABLE  = 8,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int GATE_CYCLES  = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       en,
    input  logic       pll_lock,
    output logic       power,
    output logic       gate,
    output logic       clk_ready,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_PWRUP = 3'd1,
        S_LOCK  = 3'd2,
        S_RUN   = 3'd3,
        S_GATE  = 3'd4,
        S_PWRDN = 3'd5,
        S_FAULT = 3'd6
    } state_t;

    localparam longint CNT_LIMIT = (64'd1 << CNT_W) - 64'd1;

    if (PWR_CYCLES < 1 || LOCK_STABLE < 1 || GATE_CYCLES < 1 ||
        LOCK_TIMEOUT <= LOCK_STABLE + 2 ||
        longint'(PWR_CYCLES) > CNT_LIMIT || longint'(LOCK_STABLE) > CNT_LIMIT ||
        longint'(LOCK_TIMEOUT) > CNT_LIMIT || longint'(GATE_CYCLES) > CNT_LIMIT) begin : g_param_check
        $error("pll_power_sequencer: parameter out of range for CNT_W=%0d", CNT_W);
    end

    // Terminal counts; dwell states leave when the counter reaches N-1, so they last exactly N cycles.
    localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(PWR_CYCLES - 1);
    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_N  = CNT_W'(LOCK_STABLE);
    localparam logic [CNT_W-1:0] TIMEOUT_N = CNT_W'(LOCK_TIMEOUT);

    state_t           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stable_q, stable_d;
    logic             lock_meta, lock_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign state = st_q;

    // Two-flop synchronizer for the asynchronous lock indicator.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // Next-state and counter update; cnt doubles as the LOCK timeout counter.
    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        case (st_q)
            S_OFF: begin
                if (en) begin
                    st_d  = S_PWRUP;
                    cnt_d = '0;
                end
            end
            S_PWRUP: begin
                if (!en) begin
                    st_d  = S_PWRDN;
                    cnt_d = '0;
                end else if (cnt_q >= PWR_LAST) begin
                    st_d     = S_LOCK;
                    cnt_d    = '0;
                    stable_d = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            S_LOCK: begin
                stable_d = lock_s ? sat_inc(stable_q) : '0;
                cnt_d    = sat_inc(cnt_q);
                if (!en) begin
                    st_d     = S_GATE;
                    cnt_d    = '0;
                    stable_d = '0;
                end else if (stable_d >= STABLE_N) begin
                    st_d     = S_RUN;
                    cnt_d    = '0;
                    stable_d = '0;
                end else if (cnt_d >= TIMEOUT_N) begin
                    st_d     = S_FAULT;
                    cnt_d    = '0;
                    stable_d = '0;
                end
            end
            S_RUN: begin
                if (!en) begin
                    st_d  = S_GATE;
                    cnt_d = '0;
                end else if (!lock_s) begin
                    st_d     = S_LOCK;
                    cnt_d    = '0;
                    stable_d = '0;
                end
            end
            S_GATE: begin
                if (cnt_q >= GATE_LAST) begin
                    st_d  = S_PWRDN;
                    cnt_d = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            S_PWRDN: begin
                if (cnt_q >= PWR_LAST) begin
                    st_d  = S_OFF;
                    cnt_d = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            S_FAULT: begin
                if (!en) begin
                    st_d  = S_OFF;
                    cnt_d = '0;
                end
            end
            default: begin
                st_d     = S_OFF;
                cnt_d    = '0;
                stable_d = '0;
            end
        endcase
    end

    // State, counters and Moore outputs decoded from the next state so outputs track state exactly.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st_q      <= S_OFF;
            cnt_q     <= '0;
            stable_q  <= '0;
            power     <= 1'b0;
            gate      <= 1'b1;
            clk_ready <= 1'b0;
            fault     <= 1'b0;
        end else begin
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            power     <= (st_d == S_PWRUP) || (st_d == S_LOCK) || (st_d == S_RUN) || (st_d == S_GATE);
            gate      <= (st_d != S_RUN);
            clk_ready <= (st_d == S_RUN);
            fault     <= (st_d == S_FAULT);
        end
    end

endmodule

// File: tb/tb_pll_power_sequencer.sv
// Directed bench for pll_power_sequencer with a cycle-stamped expectation queue.
module tb_pll_power_sequencer;

    logic       clock;
    logic       reset_n;
    logic       en;
    logic       pll_lock;
    logic       power;
    logic       gate;
    logic       clk_ready;
    logic       fault;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;
    int ncyc   = 0;

    typedef struct {
        int         due;
        string      tag;
        logic [6:0] exp;
    } sb_t;

    sb_t sbq[$];

    localparam logic [2:0] OFF = 3'd0, PWRUP = 3'd1, LOCK = 3'd2, RUN = 3'd3,
                           GATE = 3'd4, PWRDN = 3'd5, FLT = 3'd6;

    pll_power_sequencer dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .en        (en),
        .pll_lock  (pll_lock),
        .power     (power),
        .gate      (gate),
        .clk_ready (clk_ready),
        .fault     (fault),
        .state     (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected {state, power, gate, clk_ready, fault} from the output table.
    function automatic logic [6:0] exp_of(input logic [2:0] st);
        logic [3:0] o;
        case (st)
            OFF:     o = 4'b0100;
            PWRUP:   o = 4'b1100;
            LOCK:    o = 4'b1100;
            RUN:     o = 4'b1010;
            GATE:    o = 4'b1100;
            PWRDN:   o = 4'b0100;
            FLT:     o = 4'b0101;
            default: o = 4'b0100;
        endcase
        return {st, o};
    endfunction

    function automatic logic [6:0] observed();
        return {state, power, gate, clk_ready, fault};
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Queue an expectation k clock edges from now.
    task automatic expect_in(input int k, input string tag, input logic [2:0] st);
        sb_t e;
        e.due = ncyc + k;
        e.tag = tag;
        e.exp = exp_of(st);
        sbq.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    // Scoreboard pop/compare and invariant check, away from the active edge.
    always @(negedge clock) begin
        ncyc++;
        while (sbq.size() > 0 && sbq[0].due <= ncyc) begin
            sb_t e;
            e = sbq.pop_front();
            check(e.tag, observed(), e.exp);
        end
        if (reset_n) begin
            check("inv_gate_power", {6'd0, (gate == 1'b0 && power == 1'b0)}, 7'd0);
            check("inv_gate_run", {6'd0, (gate == 1'b0 && state != RUN)}, 7'd0);
        end
    end

    initial begin
        en       = 1'b0;
        pll_lock = 1'b0;
        reset_n  = 1'b1;
        #1 reset_n = 1'b0;
        wait_cyc(2);
        check("reset_state", observed(), exp_of(OFF));
        reset_n = 1'b1;

        // Normal power-up with lock already present.
        pll_lock = 1'b1;
        wait_cyc(3);
        check("idle_off", observed(), exp_of(OFF));
        en = 1'b1;
        expect_in(1,  "up_pwrup_first", PWRUP);
        expect_in(16, "up_pwrup_last",  PWRUP);
        expect_in(17, "up_lock_first",  LOCK);
        expect_in(24, "up_lock_last",   LOCK);
        expect_in(25, "up_run",         RUN);
        wait_cyc(26);

        // Relock: lock lost for 3 cycles.
        pll_lock = 1'b0;
        expect_in(2,  "relock_still_run", RUN);
        expect_in(3,  "relock_lock",      LOCK);
        expect_in(12, "relock_lock_last", LOCK);
        expect_in(13, "relock_run",       RUN);
        wait_cyc(3);
        pll_lock = 1'b1;
        wait_cyc(11);

        // Shutdown, with en re-asserted during PWRDN.
        en = 1'b0;
        expect_in(1,  "sd_gate_first",  GATE);
        expect_in(4,  "sd_gate_last",   GATE);
        expect_in(5,  "sd_pwrdn_first", PWRDN);
        expect_in(20, "sd_pwrdn_last",  PWRDN);
        expect_in(21, "sd_off",         OFF);
        expect_in(22, "sd_rerequest",   PWRUP);
        wait_cyc(8);
        en = 1'b1;
        wait_cyc(14);

        // Abort from mid-PWRUP.
        en = 1'b0;
        expect_in(1,  "abort_pwrdn",      PWRDN);
        expect_in(16, "abort_pwrdn_last", PWRDN);
        expect_in(17, "abort_off",        OFF);
        wait_cyc(18);

        // Short en pulse of 5 cycles.
        en = 1'b1;
        expect_in(1,  "pulse_pwrup",      PWRUP);
        expect_in(5,  "pulse_pwrup_last", PWRUP);
        expect_in(6,  "pulse_pwrdn",      PWRDN);
        expect_in(21, "pulse_pwrdn_last", PWRDN);
        expect_in(22, "pulse_off",        OFF);
        wait_cyc(5);
        en = 1'b0;
        wait_cyc(18);

        // Glitchy lock: toggles every 5 cycles, lock never qualifies -> timeout.
        en = 1'b1;
        expect_in(17,   "glitch_lock",      LOCK);
        expect_in(500,  "glitch_lock_mid",  LOCK);
        expect_in(1040, "glitch_lock_last", LOCK);
        expect_in(1041, "glitch_fault",     FLT);
        expect_in(1048, "glitch_fault_hold", FLT);
        for (int i = 0; i < 210; i++) begin
            pll_lock = ~pll_lock;
            wait_cyc(5);
        end
        en = 1'b0;
        expect_in(1, "fault_clear_off", OFF);
        wait_cyc(2);

        // Reach RUN again, then assert reset asynchronously.
        pll_lock = 1'b1;
        wait_cyc(3);
        en = 1'b1;
        expect_in(25, "rst_prep_run", RUN);
        wait_cyc(26);
        reset_n = 1'b0;
        #1;
        check("async_reset", observed(), exp_of(OFF));
        wait_cyc(2);
        check("reset_hold", observed(), exp_of(OFF));
        en = 1'b0;
        reset_n = 1'b1;
        wait_cyc(2);

        check("sb_drained", {6'd0, (sbq.size() != 0)}, 7'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
